// File: rtl/multicycle_mem_responder.sv
// rtl/multicycle_mem_responder.sv - fixed-latency pipelined 16-bit word memory responder
// Reads sample the array at the request edge and emerge LATENCY cycles later in issue order.
module multicycle_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic [3:0]  outstanding
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [15:0]          mem_array [DEPTH];
  logic [ADDR_BITS-1:0] word_idx;
  logic                 rd_accept;
  logic                 wr_accept;

  logic [LATENCY-1:0]   valid_q, valid_d;
  logic [15:0]          data_q [LATENCY];
  logic [15:0]          data_d [LATENCY];
  logic [3:0]           outstanding_q, outstanding_d;

  // Byte-lane bit and address bits above the implemented size are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[0], addr[15:ADDR_BITS+1]};

  assign word_idx  = addr[ADDR_BITS:1];
  assign rd_accept = enable & ~wr;
  assign wr_accept = enable & wr;

  // Array contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept) begin
      mem_array[word_idx] <= data_in;
    end
  end

  always_comb begin
    valid_d    = '0;
    data_d     = '{default: 16'h0000};
    valid_d[0] = rd_accept;
    data_d[0]  = rd_accept ? mem_array[word_idx] : 16'h0000;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  assign data_valid = valid_q[LATENCY-1];
  assign data_out   = data_valid ? data_q[LATENCY-1] : 16'h0000;

  // Accept and retire in the same cycle cancel, so the count tracks live pipeline entries.
  always_comb begin
    outstanding_d = outstanding_q + 4'(rd_accept) - 4'(data_valid);
  end

  assign outstanding = outstanding_q;
  assign busy        = (outstanding_q != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      data_q        <= '{default: 16'h0000};
      outstanding_q <= 4'd0;
    end else begin
      valid_q       <= valid_d;
      data_q        <= data_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// tb/tb_multicycle_mem_responder.sv - bench for multicycle_mem_responder
// Expected read data and arrival cycles are queued at issue and checked on every data_valid.
module tb_multicycle_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic [3:0]  outstanding;

  multicycle_mem_responder #(.ADDR_BITS(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          issue;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   max_out = 0;
  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int   pend;
    exp_t e;
    pend = 0;
    foreach (sb[i]) if (sb[i].issue < cyc) pend++;
    check("outstanding", {12'h0, outstanding}, 16'(pend));
    check("busy", {15'h0, busy}, {15'h0, pend != 0});
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
    if (data_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_data_valid", 16'h1, 16'h0);
      end else begin
        e = sb.pop_front();
        check("read_data", data_out, e.data);
        check("read_latency", 16'(cyc - e.issue), 16'(LAT));
      end
    end else begin
      check("data_out_idle_zero", data_out, 16'h0000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp);
    enable  = 1'b1;
    wr      = w;
    addr    = a;
    data_in = d;
    if (!w) sb.push_back('{data: exp, issue: cyc});
    step();
    enable  = 1'b0;
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    check("drain_queue_empty", 16'(sb.size()), 16'h0);
  endtask

  initial begin
    // Reset state, requests ignored while in reset
    step();
    enable = 1'b1; wr = 1'b0; addr = 16'h0000;
    step(); step();
    enable = 1'b0;
    check("reset_data_valid", {15'h0, data_valid}, 16'h0);
    check("reset_outstanding", {12'h0, outstanding}, 16'h0);
    check("reset_busy", {15'h0, busy}, 16'h0);
    check("reset_data_out", data_out, 16'h0000);
    rst_n = 1'b1;
    idle(2);

    vecs.push_back('{1, 16'h0010, 16'hBEEF, 16'h0});
    vecs.push_back('{0, 16'h0010, 16'h0, 16'hBEEF});
    for (int i = 0; i < 8; i++) vecs.push_back('{1, 16'(16'h0020 + 2*i), 16'(16'h1000 + i), 16'h0});
    for (int i = 0; i < 8; i++) vecs.push_back('{0, 16'(16'h0020 + 2*i), 16'h0, 16'(16'h1000 + i)});
    vecs.push_back('{1, 16'h0000, 16'hA5A5, 16'h0});
    vecs.push_back('{0, 16'h0001, 16'h0, 16'hA5A5});
    vecs.push_back('{0, 16'h0000, 16'h0, 16'hA5A5});
    vecs.push_back('{0, 16'h0800, 16'h0, 16'hA5A5});
    vecs.push_back('{1, 16'h0802, 16'h5A5A, 16'h0});
    vecs.push_back('{0, 16'h0002, 16'h0, 16'h5A5A});
    max_out = 0;
    for (int i = 0; i < vecs.size(); i++) issue(vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp);
    drain();
    check("burst_peak_outstanding", 16'(max_out), 16'(LAT));

    // Read followed by write to the same word returns the old value
    issue(1, 16'h0040, 16'h1111, 16'h0);
    issue(0, 16'h0040, 16'h0, 16'h1111);
    issue(1, 16'h0040, 16'h2222, 16'h0);
    issue(0, 16'h0040, 16'h0, 16'h2222);
    drain();

    // Reset with reads in flight discards them
    issue(0, 16'h0010, 16'h0, 16'hBEEF);
    issue(0, 16'h0020, 16'h0, 16'h1000);
    issue(0, 16'h0022, 16'h0, 16'h1001);
    rst_n = 1'b0;
    sb.delete();
    step();
    check("midreset_outstanding", {12'h0, outstanding}, 16'h0);
    check("midreset_busy", {15'h0, busy}, 16'h0);
    rst_n = 1'b1;
    idle(LAT + 3);
    check("postreset_outstanding", {12'h0, outstanding}, 16'h0);
    check("postreset_busy", {15'h0, busy}, 16'h0);

    // Alternating write/read every cycle
    max_out = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) issue(1, 16'(16'h0080 + 2*i), 16'(16'h3000 + i), 16'h0);
      else            issue(0, 16'(16'h0080 + 2*(i-1)), 16'h0, 16'(16'h3000 + i - 1));
    end
    drain();
    check("toggle_max_outstanding_le_lat", {15'h0, max_out <= LAT}, 16'h1);

    // Long back-to-back run keeps the pipe full without bubbles
    max_out = 0;
    for (int i = 0; i < 10; i++) issue(0, 16'(16'h0080 + 4*(i % 6)), 16'h0, 16'(16'h3000 + 2*(i % 6)));
    drain();
    check("stream_peak_outstanding", 16'(max_out), 16'(LAT));
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_mem_responder.md
MULTICYCLE_MEM_RESPONDER -- requirements
Module: multicycle_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word-address bits implemented (2^ADDR_BITS 16-bit words).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from read request to data_valid; legal range 1..8.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  request strobe, one request per asserted cycle.
REQ-006 SHALL have port wr  input  1  1 = write request, 0 = read request; ignored when enable=0.
REQ-007 SHALL have port addr  input  16  byte address; bit 0 ignored, bits [ADDR_BITS:1] select word, higher bits ignored.
REQ-008 SHALL have port data_in  input  16  write data.
REQ-009 SHALL have port data_out  output  16  read data, meaningful only when data_valid=1.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse per returned read word.
REQ-011 SHALL have port busy  output  1  1 while any read is in flight.
REQ-012 SHALL have port outstanding  output  4  number of reads in flight, 0..LATENCY.

Function
REQ-013 SHALL act as the memory-side responder for the cache fill engine: no backpressure, a request is accepted on every cycle with enable=1.
REQ-014 SHALL perform a write (enable=1, wr=1) to the addressed word at the rising edge of that cycle; writes never produce data_valid.
REQ-015 SHALL sample read data for a read (enable=1, wr=0) from the array at the request edge, so a write at cycle N is visible to a read issued at N+1 or later.
REQ-016 SHALL return a read issued at edge N with data_valid=1 and data_out=sampled word during cycle N+LATENCY, i.e. registered after LATENCY edges.
REQ-017 SHALL pipeline reads: back-to-back reads on consecutive cycles return on consecutive cycles, in issue order, with no bubbles.
REQ-018 SHALL implement the pipeline as a LATENCY-stage shift register of {valid, 16-bit data}; stage 0 loads on request, last stage drives data_out/data_valid.
REQ-019 SHALL return data sampled at issue for a read at N followed by a write to the same word at N+1: the old value.
REQ-020 SHALL drive data_out=16'h0000 in any cycle where data_valid=0.
REQ-021 SHALL maintain outstanding as a counter: +1 on read accept, -1 on data_valid, unchanged when both occur in the same cycle; never exceeds LATENCY and never underflows.
REQ-022 SHALL assert busy = (outstanding != 0), combinationally from the counter.
REQ-023 SHALL return an 8-word fill burst (reads to addr A, A+2, ... A+14 on 8 consecutive cycles) as 8 consecutive data_valid pulses beginning LATENCY cycles after the first request.
REQ-024 SHALL wrap addresses beyond 2^ADDR_BITS words modulo the implemented size (upper bits ignored).

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear all pipeline valid bits, data_out=0, data_valid=0, outstanding=0, busy=0.
REQ-026 SHALL discard reads in flight when reset asserts mid-operation; no data_valid pulse for them after rst_n deasserts.
REQ-027 SHALL ignore requests while rst_n=0 (no array write, no read accepted).
REQ-028 SHALL not reset memory array contents; contents are undefined until written.

Verification
REQ-029 SHALL pass: write 16'hBEEF to addr 16'h0010, then read 16'h0010 next cycle -> data_valid high exactly 4 cycles later (LATENCY=4) with data_out=16'hBEEF.
REQ-030 SHALL pass: write 16'h1000+i to addr 16'h0020+2i for i=0..7, then 8 back-to-back reads -> 8 consecutive data_valid pulses returning 16'h1000..16'h1007 in order; outstanding peaks at 4.
REQ-031 SHALL pass: read addr 16'h0040 (holding 16'h1111), next cycle write 16'h2222 to 16'h0040 -> returned data 16'h1111; a subsequent read returns 16'h2222.
REQ-032 SHALL pass: issue 3 reads, assert rst_n=0 for 1 cycle after 2nd return is pending -> data_valid stays 0 during and after reset, outstanding=0, busy=0.
REQ-033 SHALL pass: read addr 16'h0001 and 16'h0000 after writing 16'hA5A5 to 16'h0000 -> both return 16'hA5A5; with ADDR_BITS=10, addr 16'h0800 aliases 16'h0000.
REQ-034 SHALL pass: reads with enable=1 and wr toggling every cycle -> only read cycles yield data_valid, outstanding never exceeds LATENCY.
